// File: rtl/ifm_pkg.sv
// Shared types and AXI/ISA constants for the instruction-fetch read master.
package ifm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } ifm_state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

endpackage

// File: rtl/ifm_hit_buf.sv
// One-entry {vld,addr,inst} fetch buffer; only built when IFM_HIT_BUF_EN is defined.
module ifm_hit_buf
  import ifm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_inst,
  input  logic        fill,
  input  logic [13:0] fill_addr,
  input  logic [31:0] fill_inst,
  input  logic        inval
);

  logic        vld;
  logic [13:0] addr;
  logic [31:0] inst;

  // Invalidate wins over fill so an error never leaves a usable entry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      addr <= '0;
      inst <= INST_NOP;
    end else if (inval) begin
      vld <= 1'b0;
    end else if (fill) begin
      vld  <= 1'b1;
      addr <= fill_addr;
      inst <= fill_inst;
    end
  end

  assign hit      = vld && (lookup_addr == addr);
  assign hit_inst = inst;

endmodule

// File: rtl/if_axi_read_master.sv
// IF-stage AXI4 single-beat read master with flush drop and stall generation.
// Optional one-entry hit buffer enabled by defining IFM_HIT_BUF_EN.
//
// state | meaning
// IDLE  | waiting for req_valid; drop cleared
// ADDR  | ARVALID held until ARREADY
// DATA  | RREADY high until the beat with RID==AR_ID
// RESP  | rsp_valid pulse (unless flushed this cycle)
module if_axi_read_master
  import ifm_pkg::*;
#(
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] AR_ID     = '0,
  parameter logic [31:0]     BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [13:0]     req_addr,
  input  logic            flush,
  output logic            rsp_valid,
  output logic [31:0]     rsp_inst,
  output logic            rsp_err,
  output logic            stall,
  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [3:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,
  input  logic [ID_W-1:0] RID,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY
);

  ifm_state_t  state, state_d;
  logic [13:0] addr_q;
  logic        drop, drop_d;
  logic        ld_addr, hit_take, beat, resp_ok, deliver;
  logic        buf_hit;
  logic [31:0] buf_inst;
  logic        unused_rlast;

  assign unused_rlast = RLAST;
  assign beat    = (state == DATA) && RVALID && (RID == AR_ID);
  assign resp_ok = (RRESP == AXI_RESP_OKAY);
  assign deliver = beat && !(drop || flush);

`ifdef IFM_HIT_BUF_EN
  ifm_hit_buf u_hit_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(req_addr),
    .hit        (buf_hit),
    .hit_inst   (buf_inst),
    .fill       (deliver && resp_ok),
    .fill_addr  (addr_q),
    .fill_inst  (RDATA),
    .inval      (beat && !resp_ok)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_inst = INST_NOP;
`endif

  always_comb begin
    state_d  = state;
    drop_d   = drop;
    ld_addr  = 1'b0;
    hit_take = 1'b0;
    case (state)
      IDLE: begin
        drop_d = 1'b0;
        if (req_valid) begin
          ld_addr = 1'b1;
          if (buf_hit) begin
            hit_take = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (flush)   drop_d  = 1'b1;
        if (ARREADY) state_d = DATA;
      end
      DATA: begin
        if (flush) drop_d = 1'b1;
        if (beat)  state_d = (drop || flush) ? IDLE : RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      drop     <= 1'b0;
      addr_q   <= '0;
      rsp_inst <= INST_NOP;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_d;
      drop  <= drop_d;
      if (ld_addr) addr_q <= req_addr;
      // Errored fetches hand ID a NOP so nothing stale is ever decoded.
      if (hit_take) begin
        rsp_inst <= buf_inst;
        rsp_err  <= 1'b0;
      end else if (deliver) begin
        rsp_inst <= resp_ok ? RDATA : INST_NOP;
        rsp_err  <= !resp_ok;
      end
    end
  end

  assign rsp_valid = (state == RESP) && !flush;
  assign stall     = req_valid && !rsp_valid;

  assign ARVALID = (state == ADDR);
  assign ARID    = AR_ID;
  assign ARADDR  = BASE_ADDR + {16'h0000, addr_q, 2'b00};
  assign ARLEN   = 4'd0;
  assign ARSIZE  = AXI_SIZE_4B;
  assign ARBURST = AXI_BURST_INCR;
  assign RREADY  = (state == DATA);

endmodule

// File: tb/tb_if_axi_read_master.sv
// Directed + randomized bench for if_axi_read_master with a cycle-scheduled AXI slave
// and a transaction-level model of delivered instructions and the optional hit buffer.
module tb_if_axi_read_master;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [3:0]  MYID = 4'h0;
`ifdef IFM_HIT_BUF_EN
  localparam bit HIT_BUF = 1'b1;
`else
  localparam bit HIT_BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [13:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid, rsp_err, stall;
  logic [31:0] rsp_inst;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, RREADY;
  logic        ARREADY = 1'b0;
  logic [3:0]  RID = '0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 1'b1;
  logic        RVALID = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // transaction-level model
  logic [31:0] m_inst = NOP;
  logic        m_err = 1'b0;
  bit          m_known = 1'b1;
  bit          b_vld = 1'b0;
  logic [13:0] b_addr = '0;
  logic [31:0] b_inst = NOP;

  always #5 clk = ~clk;

  if_axi_read_master #(.ID_W(4), .AR_ID(MYID), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_err(rsp_err), .stall(stall),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_hit(input logic [13:0] a);
    return HIT_BUF && b_vld && (b_addr == a);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0; flush = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
      #1;
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_arvalid", 32'(ARVALID), 32'd0);
      @(negedge clk);
    end
  endtask

  // One IF fetch; cycle 0 is the cycle req_valid is first presented.
  // flush_at < 0 means no flush.
  task automatic do_fetch(input logic [13:0] a, input int ar_wait, input int r_wait,
                          input logic [1:0] resp, input int flush_at, input bit bad_rid,
                          input logic [31:0] data);
    bit hit, dropped, rflush, exp_arv, exp_rr, exp_rv;
    int c_h, c_b, c_rsp;
    logic [31:0] exp_inst;
    hit     = exp_hit(a);
    c_h     = 1 + ar_wait;
    c_b     = c_h + 1 + r_wait;
    c_rsp   = hit ? 1 : c_b + 1;
    dropped = !hit && flush_at >= 1 && flush_at <= c_b;
    rflush  = (flush_at == c_rsp);
    exp_inst = hit ? b_inst : ((resp == 2'b00) ? data : NOP);
    for (int c = 0; c <= c_rsp; c++) begin
      req_valid = !(dropped && c == c_rsp);
      req_addr  = a;
      flush     = (c == flush_at);
      ARREADY   = !hit && (c == c_h);
      RVALID    = 1'b0;
      RID       = MYID;
      RDATA     = $urandom;
      RRESP     = 2'($urandom_range(0, 3));
      RLAST     = 1'b1;
      if (!hit && c == c_b) begin
        RVALID = 1'b1; RDATA = data; RRESP = resp;
      end else if (!hit && bad_rid && c > c_h && c < c_b) begin
        RVALID = 1'b1; RID = 4'($urandom_range(1, 15));
      end
      exp_arv = !hit && c >= 1 && c <= c_h;
      exp_rr  = !hit && c > c_h && c <= c_b;
      exp_rv  = (c == c_rsp) && !dropped && !rflush;
      #1;
      chk("arvalid", 32'(ARVALID), 32'(exp_arv));
      if (exp_arv) begin
        chk("araddr", ARADDR, BASE + {16'h0000, a, 2'b00});
        chk("ar_attr", {17'h0, ARID, ARLEN, ARSIZE, ARBURST}, {17'h0, MYID, 4'd0, 3'b010, 2'b01});
      end
      chk("rready", 32'(RREADY), 32'(exp_rr));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("stall", 32'(stall), 32'(req_valid && !exp_rv));
      if (exp_rv) begin
        chk("rsp_inst", rsp_inst, exp_inst);
        chk("rsp_err", 32'(rsp_err), 32'(!hit && resp != 2'b00));
      end
      @(negedge clk);
    end
    req_valid = 1'b0; flush = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
    if (hit) begin
      if (rflush) m_known = 1'b0;
      else begin m_inst = b_inst; m_err = 1'b0; end
    end else if (dropped) begin
      if (resp != 2'b00) b_vld = 1'b0;
    end else begin
      if (rflush) m_known = 1'b0;
      else begin m_inst = exp_inst; m_err = (resp != 2'b00); end
      if (resp == 2'b00) begin b_vld = 1'b1; b_addr = a; b_inst = data; end
      else b_vld = 1'b0;
    end
    #1;
    if (m_known) chk("rsp_inst_hold", rsp_inst, m_inst);
    chk("back_idle_arvalid", 32'(ARVALID), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_rsp_inst", rsp_inst, NOP);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_rready", 32'(RREADY), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // basic fetch, zero-wait slave
    do_fetch(14'h0004, 0, 0, 2'b00, -1, 1'b0, 32'h00A0_0093);
    idle(1);
    // ARREADY withheld for 5 cycles
    do_fetch(14'h0040, 5, 1, 2'b00, -1, 1'b0, 32'h1234_5678);
    idle(1);
    // flush in DATA, beat two cycles later, wrong-RID beats ignored meanwhile
    do_fetch(14'h0100, 0, 2, 2'b00, 2, 1'b1, 32'hDEAD_BEEF);
    idle(1);
    // flush on the handshake cycle of AR
    do_fetch(14'h0104, 2, 0, 2'b00, 3, 1'b0, 32'hCAFE_0001);
    // error response
    do_fetch(14'h0200, 0, 0, 2'b10, -1, 1'b0, 32'h5555_AAAA);
    idle(2);
    // flush in RESP suppresses the pulse
    do_fetch(14'h0020, 0, 0, 2'b10, 3, 1'b0, 32'h0BAD_0BAD);
    do_fetch(14'h0024, 1, 1, 2'b00, -1, 1'b0, 32'h0000_0517);

    // reset while in DATA
    req_valid = 1'b1; req_addr = 14'h0123;
    @(negedge clk);
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    #1;
    chk("pre_rst_rready", 32'(RREADY), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_arvalid", 32'(ARVALID), 32'd0);
    chk("mid_rst_rready", 32'(RREADY), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_inst", rsp_inst, NOP);
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_inst = NOP; m_err = 1'b0; m_known = 1'b1; b_vld = 1'b0;
    idle(1);
    do_fetch(14'h0000, 0, 0, 2'b00, -1, 1'b0, 32'h0000_0297);
    idle(1);

`ifdef IFM_HIT_BUF_EN
    do_fetch(14'h0008, 0, 0, 2'b00, -1, 1'b0, 32'h0040_0113);
    chk("buf_expect_hit", 32'(exp_hit(14'h0008)), 32'd1);
    do_fetch(14'h0008, 0, 0, 2'b00, -1, 1'b0, 32'hFFFF_FFFF);
    do_fetch(14'h0010, 0, 0, 2'b11, -1, 1'b0, 32'h0);
    chk("buf_expect_miss", 32'(exp_hit(14'h0008)), 32'd0);
    do_fetch(14'h0008, 0, 0, 2'b00, -1, 1'b0, 32'h0080_0193);
    idle(1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [13:0] a;
      int          aw, rw, fa;
      logic [1:0]  rr;
      a  = 14'($urandom_range(0, 3) * 4);
      aw = int'($urandom_range(0, 3));
      rw = int'($urandom_range(0, 3));
      rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fa = -1;
      if (!exp_hit(a) && $urandom_range(0, 4) == 0) fa = int'($urandom_range(1, 2 + aw + rw));
      do_fetch(a, aw, rw, rr, fa, 1'($urandom_range(0, 1)), $urandom);
      idle(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
